// File: rtl/synth_pkg.sv
// Shared types and default widths for the polyphonic synth datapath.
package synth_pkg;

  localparam int unsigned DIV_W    = 16;
  localparam int unsigned SAMPLE_W = 8;

  typedef enum logic [1:0] {
    WAVE_SQUARE = 2'b00,
    WAVE_SAW    = 2'b01,
    WAVE_TRI    = 2'b10,
    WAVE_OFF    = 2'b11
  } wave_mode_t;

endpackage

// File: rtl/voice_osc.sv
// One voice: divider prescaler, wrapping step counter and waveform decode.
module voice_osc #(
  parameter int unsigned DIV_W    = synth_pkg::DIV_W,
  parameter int unsigned SAMPLE_W = synth_pkg::SAMPLE_W
) (
  input  logic                clk,
  input  logic                nrst,
  input  logic                en_i,
  input  logic [DIV_W-1:0]    div_i,
  input  logic [1:0]          mode_i,
  output logic [SAMPLE_W-1:0] sample_o
);
  import synth_pkg::*;

  logic [DIV_W-1:0]    cnt;
  logic [SAMPLE_W-1:0] step;
  logic [SAMPLE_W-1:0] step_x2;
  logic                wrap;
  wave_mode_t          mode;

  // >= rather than == so a divider lowered below cnt wraps at once
  assign wrap = (cnt >= (div_i - DIV_W'(1)));

  // Prescaler and step counter; disabled or div=0 holds both at zero
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cnt  <= '0;
      step <= '0;
    end else if (!en_i || (div_i == '0)) begin
      cnt  <= '0;
      step <= '0;
    end else if (wrap) begin
      cnt  <= '0;
      step <= step + SAMPLE_W'(1);
    end else begin
      cnt  <= cnt + DIV_W'(1);
    end
  end

  // Waveform decode from the step phase; gated by enable
  always_comb begin
    sample_o = '0;
    mode     = wave_mode_t'(mode_i);
    step_x2  = step << 1;
    if (en_i) begin
      case (mode)
        WAVE_SQUARE: sample_o = {SAMPLE_W{step[SAMPLE_W-1]}};
        WAVE_SAW:    sample_o = step;
        WAVE_TRI:    sample_o = step[SAMPLE_W-1] ? ~step_x2 : step_x2;
        default:     sample_o = '0;
      endcase
    end
  end

endmodule

// File: rtl/poly_voice_synth.sv
// Polyphonic synth: NUM_VOICES oscillators, averaging mixer, single PWM output.
module poly_voice_synth #(
  parameter int unsigned NUM_VOICES = 4,
  parameter int unsigned DIV_W      = synth_pkg::DIV_W,
  parameter int unsigned SAMPLE_W   = synth_pkg::SAMPLE_W
) (
  input  logic                        clk,
  input  logic                        nrst,
  input  logic [NUM_VOICES-1:0]       voice_en_i,
  input  logic [NUM_VOICES*DIV_W-1:0] voice_div_i,
  input  logic [1:0]                  mode_i,
  output logic                        pwm_o,
  output logic                        sample_strobe_o
);
  import synth_pkg::*;

  localparam int unsigned MIX_SH = $clog2(NUM_VOICES);
  localparam int unsigned SUM_W  = SAMPLE_W + MIX_SH;

  logic [SAMPLE_W-1:0] samples [NUM_VOICES];
  logic [SUM_W-1:0]    mix_sum;
  logic [SAMPLE_W-1:0] mix_q;
  logic [SAMPLE_W-1:0] pwm_cnt;
  logic [SAMPLE_W-1:0] duty_q;

  // Voice oscillators
  for (genvar i = 0; i < NUM_VOICES; i++) begin : g_voice
    voice_osc #(
      .DIV_W    (DIV_W),
      .SAMPLE_W (SAMPLE_W)
    ) u_osc (
      .clk      (clk),
      .nrst     (nrst),
      .en_i     (voice_en_i[i]),
      .div_i    (voice_div_i[i*DIV_W +: DIV_W]),
      .mode_i   (mode_i),
      .sample_o (samples[i])
    );
  end

  // Sum of all voice samples, wide enough never to overflow
  always_comb begin
    mix_sum = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      mix_sum = mix_sum + SUM_W'(samples[i]);
    end
  end

  // Mixer: divide by the full voice count, not the active count
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      mix_q <= '0;
    end else begin
      mix_q <= SAMPLE_W'(mix_sum >> MIX_SH);
    end
  end

  // PWM counter; duty only reloads at the period boundary
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      pwm_cnt         <= '0;
      duty_q          <= '0;
      sample_strobe_o <= 1'b0;
    end else begin
      pwm_cnt         <= pwm_cnt + SAMPLE_W'(1);
      sample_strobe_o <= 1'b0;
      if (pwm_cnt == '1) begin
        duty_q          <= mix_q;
        sample_strobe_o <= 1'b1;
      end
    end
  end

  assign pwm_o = (pwm_cnt < duty_q);

endmodule

// File: tb/tb_poly_voice_synth.sv
// Self-checking bench for poly_voice_synth with a reference model and duty scoreboard.
module tb_poly_voice_synth;

  logic        clk = 1'b0;
  logic        nrst;
  logic [3:0]  voice_en_i;
  logic [63:0] voice_div_i;
  logic [1:0]  mode_i;
  logic        pwm_o;
  logic        sample_strobe_o;

  int n_checks = 0;
  int n_err    = 0;
  int sb[$];
  int seen255  = 0;

  poly_voice_synth #(
    .NUM_VOICES (4),
    .DIV_W      (16),
    .SAMPLE_W   (8)
  ) dut (
    .clk             (clk),
    .nrst            (nrst),
    .voice_en_i      (voice_en_i),
    .voice_div_i     (voice_div_i),
    .mode_i          (mode_i),
    .pwm_o           (pwm_o),
    .sample_strobe_o (sample_strobe_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Expected waveform value for an 8-bit phase
  function automatic int wave(input int s, input logic [1:0] m);
    case (m)
      2'b00:   return (s >= 128) ? 255 : 0;
      2'b01:   return s;
      2'b10:   return (s < 128) ? 2 * s : 255 - ((2 * s) & 255);
      default: return 0;
    endcase
  endfunction

  // Reference model of voices, mixer and PWM period boundary
  int m_cnt [4];
  int m_step[4];
  int m_mix;
  int m_pwm;

  function automatic int model_mix();
    int s = 0;
    for (int v = 0; v < 4; v++)
      if (voice_en_i[v]) s += wave(m_step[v], mode_i);
    return s / 4;
  endfunction

  always @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int v = 0; v < 4; v++) begin
        m_cnt[v]  <= 0;
        m_step[v] <= 0;
      end
      m_mix <= 0;
      m_pwm <= 0;
    end else begin
      for (int v = 0; v < 4; v++) begin
        int d;
        d = int'(voice_div_i[v*16 +: 16]);
        if (!voice_en_i[v] || d == 0) begin
          m_cnt[v]  <= 0;
          m_step[v] <= 0;
        end else if (m_cnt[v] >= d - 1) begin
          m_cnt[v]  <= 0;
          m_step[v] <= (m_step[v] + 1) % 256;
        end else begin
          m_cnt[v]  <= m_cnt[v] + 1;
        end
      end
      m_mix <= model_mix();
      if (m_pwm == 255) begin
        m_pwm <= 0;
        sb.push_back(m_mix);
      end else begin
        m_pwm <= m_pwm + 1;
      end
    end
  end

  // Monitor: measure each PWM period between strobes against the scoreboard
  bit active = 0;
  int hi     = 0;
  int gap    = 0;
  always begin
    @(posedge clk);
    #2;
    if (!nrst) begin
      active = 0;
      sb.delete();
    end else begin
      if (sample_strobe_o) begin
        if (active) begin
          if (sb.size() == 0) begin
            chk("sb_nonempty", 32'd0, 32'd1);
          end else begin
            int e;
            e = sb.pop_front();
            if (e == 255) seen255++;
            chk("period_high_count", 32'(hi), 32'(e));
          end
          chk("strobe_gap", 32'(gap), 32'd256);
        end
        active = 1;
        hi     = 0;
        gap    = 0;
      end
      if (active) begin
        gap++;
        hi += int'(pwm_o);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic count_to_strobe(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!sample_strobe_o && n < 600);
  endtask

  task automatic set_all_div(input int d);
    for (int v = 0; v < 4; v++) voice_div_i[v*16 +: 16] = 16'(d);
  endtask

  initial begin
    int n;
    int mx;
    int bad;
    int h;
    nrst        = 1'b0;
    voice_en_i  = 4'b0000;
    voice_div_i = '0;
    mode_i      = 2'b00;

    // Reset values and strobe cadence
    repeat (5) tick();
    chk("rst_pwm", 32'(pwm_o), 32'd0);
    chk("rst_strobe", 32'(sample_strobe_o), 32'd0);
    chk("rst_mix", 32'(dut.mix_q), 32'd0);
    chk("rst_pwm_cnt", 32'(dut.pwm_cnt), 32'd0);
    nrst = 1'b1;
    count_to_strobe(n);
    chk("first_strobe", 32'(n), 32'd256);
    count_to_strobe(n);
    chk("strobe_period", 32'(n), 32'd256);

    // Single voice saw, div=1
    voice_en_i = 4'b0001;
    voice_div_i[15:0] = 16'd1;
    mode_i = 2'b01;
    mx = 0;
    for (int k = 1; k <= 300; k++) begin
      tick();
      if (int'(dut.mix_q) > mx) mx = int'(dut.mix_q);
      if (k == 5)   chk("saw_mix_k5", 32'(dut.mix_q), 32'd1);
      if (k == 101) chk("saw_mix_k101", 32'(dut.mix_q), 32'd25);
      if (k == 200) chk("saw_mix_model", 32'(dut.mix_q), 32'(m_mix));
    end
    chk("saw_peak", 32'(mx), 32'd63);
    chk("saw_step", 32'(dut.g_voice[0].u_osc.step), 32'd44);

    // Four synced voices, square, div=2
    voice_en_i = 4'b0000;
    tick();
    voice_en_i = 4'b1111;
    set_all_div(2);
    mode_i = 2'b00;
    bad = 0;
    seen255 = 0;
    for (int k = 1; k <= 1024; k++) begin
      tick();
      if (dut.mix_q != 8'd0 && dut.mix_q != 8'd255) bad++;
      if (k == 256) chk("sq_mix_low", 32'(dut.mix_q), 32'd0);
      if (k == 257) chk("sq_mix_high", 32'(dut.mix_q), 32'd255);
      if (k == 1000) begin
        chk("lock_v0", 32'(dut.g_voice[0].u_osc.step), 32'd244);
        chk("lock_v1", 32'(dut.g_voice[1].u_osc.step), 32'd244);
        chk("lock_v2", 32'(dut.g_voice[2].u_osc.step), 32'd244);
        chk("lock_v3", 32'(dut.g_voice[3].u_osc.step), 32'd244);
      end
    end
    chk("sq_levels", 32'(bad), 32'd0);
    chk("sq_full_duty_seen", 32'(seen255 != 0), 32'd1);

    // Divider edge cases
    voice_en_i = 4'b0000;
    tick();
    voice_en_i = 4'b0001;
    set_all_div(0);
    mode_i = 2'b01;
    repeat (20) tick();
    chk("div0_step", 32'(dut.g_voice[0].u_osc.step), 32'd0);
    chk("div0_mix", 32'(dut.mix_q), 32'd0);
    voice_div_i[15:0] = 16'd1000;
    repeat (500) tick();
    chk("div1000_cnt", 32'(dut.g_voice[0].u_osc.cnt), 32'd500);
    chk("div1000_step", 32'(dut.g_voice[0].u_osc.step), 32'd0);
    voice_div_i[15:0] = 16'd10;
    tick();
    chk("div_lower_step", 32'(dut.g_voice[0].u_osc.step), 32'd1);
    chk("div_lower_cnt", 32'(dut.g_voice[0].u_osc.cnt), 32'd0);
    repeat (9) tick();
    chk("div10_hold", 32'(dut.g_voice[0].u_osc.step), 32'd1);
    tick();
    chk("div10_step", 32'(dut.g_voice[0].u_osc.step), 32'd2);

    // Triangle boundary values
    voice_en_i = 4'b0000;
    tick();
    voice_en_i = 4'b0001;
    voice_div_i[15:0] = 16'd1;
    mode_i = 2'b10;
    n = 0;
    while (dut.g_voice[0].u_osc.step != 8'd127 && n < 300) begin tick(); n++; end
    chk("tri_127", 32'(dut.g_voice[0].u_osc.sample_o), 32'd254);
    tick();
    chk("tri_128", 32'(dut.g_voice[0].u_osc.sample_o), 32'd255);
    n = 0;
    while (dut.g_voice[0].u_osc.step != 8'd255 && n < 300) begin tick(); n++; end
    chk("tri_255", 32'(dut.g_voice[0].u_osc.sample_o), 32'd1);

    // Mode off mid-period: current period kept, following period silent
    count_to_strobe(n);
    repeat (100) tick();
    mode_i = 2'b11;
    count_to_strobe(n);
    count_to_strobe(n);
    h = int'(pwm_o);
    repeat (255) begin tick(); h += int'(pwm_o); end
    chk("off_period_low", 32'(h), 32'd0);

    // Asynchronous reset mid-period
    voice_en_i = 4'b1111;
    set_all_div(3);
    mode_i = 2'b01;
    n = 0;
    while (!(pwm_o && dut.pwm_cnt > 8'd10) && n < 2000) begin tick(); n++; end
    chk("pre_reset_pwm_high", 32'(pwm_o), 32'd1);
    nrst = 1'b0;
    #1;
    chk("arst_pwm", 32'(pwm_o), 32'd0);
    chk("arst_strobe", 32'(sample_strobe_o), 32'd0);
    chk("arst_pwm_cnt", 32'(dut.pwm_cnt), 32'd0);
    chk("arst_duty", 32'(dut.duty_q), 32'd0);
    chk("arst_mix", 32'(dut.mix_q), 32'd0);
    chk("arst_step", 32'(dut.g_voice[0].u_osc.step), 32'd0);
    chk("arst_cnt", 32'(dut.g_voice[0].u_osc.cnt), 32'd0);
    repeat (2) tick();
    nrst = 1'b1;
    count_to_strobe(n);
    chk("post_reset_strobe", 32'(n), 32'd256);
    count_to_strobe(n);
    count_to_strobe(n);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
